// File: rtl/flit_inject_sched.sv
// Two-requester flit injector onto a ring slot: transit traffic has priority,
// free slots are filled round-robin from per-requester FIFOs, starvation is flagged.
module flit_inject_sched #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] req0_flit,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [9:0] req1_flit,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [9:0] net_in,
    output logic [9:0] net_out,
    output logic [1:0] inj_grant,
    output logic       starve
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [7:0]  LIM = 8'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, ARB, BLOCK} state_e;

    state_e        state;
    logic [9:0]    mem_q    [2][DEPTH];
    logic [9:0]    mem_d    [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [CW-1:0] count_q  [2];
    logic [CW-1:0] count_d  [2];
    logic [9:0]    flit_in  [2];
    logic [1:0]    valid_in;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    nonempty;
    logic          winner;
    logic          rr_last_q, rr_last_d;
    logic [7:0]    blk_cnt_q, blk_cnt_d;
    logic [9:0]    net_out_q, net_out_d;
    logic [1:0]    inj_grant_q, inj_grant_d;
    logic          starve_q, starve_d;

    always_comb begin
        flit_in[0] = req0_flit;
        flit_in[1] = req1_flit;
        valid_in   = {req1_valid, req0_valid};
        for (int unsigned i = 0; i < 2; i++) begin
            // Readiness comes from the registered count only, so a full FIFO
            // refuses a push even in the cycle it pops.
            ready[i]    = (count_q[i] < CW'(DEPTH));
            nonempty[i] = (count_q[i] != '0);
        end
        push = valid_in & ready;
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        state = IDLE;
        if (nonempty != 2'b00) begin
            state = net_in[9] ? BLOCK : ARB;
        end
    end

    always_comb begin
        net_out_d   = '0;
        inj_grant_d = '0;
        pop         = '0;
        rr_last_d   = rr_last_q;
        blk_cnt_d   = '0;
        winner      = (nonempty == 2'b11) ? ~rr_last_q : ~nonempty[0];
        if (net_in[9]) begin
            net_out_d = net_in;
        end
        case (state)
            ARB: begin
                pop[winner]         = 1'b1;
                net_out_d           = mem_q[winner][rd_ptr_q[winner]];
                inj_grant_d[winner] = 1'b1;
                rr_last_d           = winner;
            end
            BLOCK: begin
                blk_cnt_d = (blk_cnt_q >= LIM) ? LIM : blk_cnt_q + 8'd1;
            end
            default: ;
        endcase
        starve_d = (blk_cnt_d == LIM);
    end

    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = {1'b1, flit_in[i][8:0]};
                wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end
            count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            count_q     <= '{default: '0};
            rr_last_q   <= 1'b1;
            blk_cnt_q   <= '0;
            net_out_q   <= '0;
            inj_grant_q <= '0;
            starve_q    <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_last_q   <= rr_last_d;
            blk_cnt_q   <= blk_cnt_d;
            net_out_q   <= net_out_d;
            inj_grant_q <= inj_grant_d;
            starve_q    <= starve_d;
        end
    end

    assign net_out   = net_out_q;
    assign inj_grant = inj_grant_q;
    assign starve    = starve_q;

endmodule
